ps2_rx_fifo: RTL and testbench

Parametrised successor to the single-byte PS/2 receiver. It adds:
- a configurable glitch filter on ps2c;
- odd-parity and stop-bit checking;
- a watchdog timeout for stalled frames;
- a first-word-fall-through receive FIFO, so the consumer (processor I/O port) can drain scan codes at its own pace.

It sits between the keyboard pins and the processor's memory-mapped input register.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_clk_filter.sv | 46 ++++
 rtl/ps2_rx_fifo.sv | 163 ++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame geometry, FSM states
// and the odd-parity rule used when a frame is accepted.
package ps2_pkg;

   localparam int PS2_DATA_BITS  = 8;
   localparam int PS2_FRAME_BITS = 11;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_t;

   // A PS/2 frame is valid when data plus parity bit carry an odd number of ones.
   function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                          input logic                     p);
      return ^{data, p};
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Brings ps2c/ps2d into the clk domain and debounces ps2c: the filtered level
// only changes after FILTER_LEN identical samples; fall_tick marks each 1->0.
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2c,
   input  logic ps2d,
   output logic data_sync,
   output logic fall_tick
);

   logic                  c_meta;
   logic                  c_sync;
   logic                  d_meta;
   logic                  clk_filt;
   logic [FILTER_LEN-1:0] window;

   // NOTE: every flop below uses <= so all stages shift together on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         c_meta    <= 1'b1;
         c_sync    <= 1'b1;
         d_meta    <= 1'b1;
         data_sync <= 1'b1;
         window    <= '1;
         clk_filt  <= 1'b1;
         fall_tick <= 1'b0;
      end else begin
         c_meta    <= ps2c;
         c_sync    <= c_meta;
         d_meta    <= ps2d;
         data_sync <= d_meta;
         window    <= {window[FILTER_LEN-2:0], c_sync};
         fall_tick <= 1'b0;
         if (&window) begin
            clk_filt <= 1'b1;
         end else if (~|window) begin
            clk_filt  <= 1'b0;
            fall_tick <= clk_filt;
         end
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver with parity/stop checking, a stalled-frame watchdog
// and a first-word-fall-through FIFO feeding the processor input port.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN   = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int TIMEOUT_CYC  = 5000,
   parameter int CHECK_PARITY = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ps2d,
   input  logic                          ps2c,
   input  logic                          rx_en,
   input  logic                          rd_en,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   output logic                          rx_done_tick,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int              AW         = $clog2(FIFO_DEPTH);
   localparam int              TW         = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [2:0]      LAST_BIT   = 3'(PS2_DATA_BITS - 1);

   logic d;
   logic fall_tick;

   ps2_clk_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_filter (
      .clk       (clk),
      .reset     (reset),
      .ps2c      (ps2c),
      .ps2d      (ps2d),
      .data_sync (d),
      .fall_tick (fall_tick)
   );

   // ---------------- frame FSM ----------------
   ps2_state_t                  state, state_next;
   logic [2:0]                  bit_cnt, bit_cnt_next;
   logic [PS2_DATA_BITS-1:0]    shreg, shreg_next;
   logic                        par_bit, par_bit_next;
   logic [TW-1:0]               timer, timer_next;
   logic                        good, perr_next, ferr_next;
   logic                        wr_pend;
   logic [PS2_DATA_BITS-1:0]    wr_byte;

   // NOTE: defaults first so no path through this block can infer a latch.
   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      shreg_next   = shreg;
      par_bit_next = par_bit;
      timer_next   = timer;
      good         = 1'b0;
      perr_next    = 1'b0;
      ferr_next    = 1'b0;

      if (state != IDLE) timer_next = timer + TW'(1);

      // The watchdog wins over an edge landing in the same cycle.
      if (state != IDLE && timer == TIMER_LAST) begin
         state_next = IDLE;
         timer_next = '0;
         ferr_next  = 1'b1;
      end else if (fall_tick) begin
         timer_next = '0;
         case (state)
            IDLE: begin
               if (rx_en && !d) begin
                  state_next   = DATA;
                  bit_cnt_next = '0;
               end
            end
            DATA: begin
               shreg_next   = {d, shreg[PS2_DATA_BITS-1:1]};
               bit_cnt_next = bit_cnt + 3'd1;
               if (bit_cnt == LAST_BIT) state_next = PARITY;
            end
            PARITY: begin
               par_bit_next = d;
               state_next   = STOP;
            end
            STOP: begin
               state_next = IDLE;
               if (!d)
                  ferr_next = 1'b1;
               else if (CHECK_PARITY != 0 && !odd_parity_ok(shreg, par_bit))
                  perr_next = 1'b1;
               else
                  good = 1'b1;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         timer      <= '0;
         wr_pend    <= 1'b0;
         wr_byte    <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_next;
         bit_cnt    <= bit_cnt_next;
         shreg      <= shreg_next;
         par_bit    <= par_bit_next;
         timer      <= timer_next;
         wr_pend    <= good;
         parity_err <= perr_next;
         frame_err  <= ferr_next;
         if (good) wr_byte <= shreg;
      end
   end

   // ---------------- receive FIFO ----------------
   logic [PS2_DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW:0]              wr_ptr, rd_ptr;
   logic                     empty, full, pop, push;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = rd_en && !empty;
   // A pop in the same cycle frees the slot the pending byte needs.
   assign push  = wr_pend && (!full || pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         rx_done_tick <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
         rx_done_tick <= push;
         overflow     <= wr_pend && !push;
      end
   end

   // NOTE: storage has no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_byte;
   end

   assign rx_valid   = !empty;
   assign fifo_count = wr_ptr - rd_ptr;
   assign rx_data    = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: a frame table plus hand sequences for glitches,
// overflow, coincident push/pop, watchdog timeout and mid-frame reset.
module tb_ps2_rx_fifo;
   import ps2_pkg::*;

   localparam int FILTER_LEN  = 4;
   localparam int TIMEOUT_CYC = 200;
   // ps2c edge to FSM update: 2 sync stages, window fill, filter flop, FSM flop.
   localparam int EDGE_LAT    = FILTER_LEN + 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2d = 1'b1;
   logic       ps2c = 1'b1;
   logic       rx_en = 1'b1;
   logic       rd_en = 1'b0;

   logic [7:0] rx_data, np_rx_data;
   logic       rx_valid, np_valid;
   logic       rx_done_tick, np_done_tick;
   logic       parity_err, np_parity_err;
   logic       frame_err, np_frame_err;
   logic       overflow, np_overflow;
   logic [2:0] fifo_count, np_count;

   always #5 clk = ~clk;

   ps2_rx_fifo #(.FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(4), .TIMEOUT_CYC(TIMEOUT_CYC), .CHECK_PARITY(1)) dut (
      .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en), .rd_en(rd_en),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_done_tick(rx_done_tick),
      .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow), .fifo_count(fifo_count));

   ps2_rx_fifo #(.FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(4), .TIMEOUT_CYC(TIMEOUT_CYC), .CHECK_PARITY(0)) dut_np (
      .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en), .rd_en(rd_en),
      .rx_data(np_rx_data), .rx_valid(np_valid), .rx_done_tick(np_done_tick),
      .parity_err(np_parity_err), .frame_err(np_frame_err), .overflow(np_overflow), .fifo_count(np_count));

   int n_checks = 0;
   int n_errors = 0;
   int n_done = 0, n_perr = 0, n_ferr = 0, n_ovf = 0;
   int np_done = 0, np_perr = 0, np_ferr = 0, np_ovf = 0;

   always @(negedge clk) begin
      if (rx_done_tick)  n_done++;
      if (parity_err)    n_perr++;
      if (frame_err)     n_ferr++;
      if (overflow)      n_ovf++;
      if (np_done_tick)  np_done++;
      if (np_parity_err) np_perr++;
      if (np_frame_err)  np_ferr++;
      if (np_overflow)   np_ovf++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_rd();
      @(negedge clk); rd_en = 1'b1;
      @(negedge clk); rd_en = 1'b0;
   endtask

   // Drives the first nbits of a frame, LSB first, with 20-clk ps2c half-periods.
   // glitch_bit inserts a 3-clk low pulse in the high phase before that bit;
   // pop_at_stop raises rd_en for the one cycle in which the stop-bit push lands.
   task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                             input int glitch_bit, input logic pop_at_stop, input int nbits);
      logic [PS2_FRAME_BITS-1:0] f;
      f = {stop, par, data, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ps2d = f[i];
         if (i == glitch_bit) begin
            wait_clk(3); ps2c = 1'b0;
            wait_clk(3); ps2c = 1'b1;
            wait_clk(4);
         end else begin
            wait_clk(10);
         end
         ps2c = 1'b0;
         for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (pop_at_stop && i == PS2_FRAME_BITS - 1) begin
               if (k == EDGE_LAT) rd_en = 1'b1;
               else if (k == EDGE_LAT + 1) begin
                  check("coincident_done_tick", 32'(rx_done_tick), 1);
                  rd_en = 1'b0;
               end
            end
         end
         ps2c = 1'b1;
         wait_clk(9);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      int         done;
      int         perr;
      int         ferr;
      int         np_done;
      logic [7:0] head;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int d_done, d_perr, d_ferr, d_ovf, d_npdone, d_npferr, d_npovf;
      int t;
      logic found;
      logic [7:0] bv;

      vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 1, 8'h1C};
      vecs[1] = '{8'h1C, 1'b1, 1'b1, 0, 1, 0, 1, 8'h00};
      vecs[2] = '{8'hAA, 1'b1, 1'b0, 0, 0, 1, 0, 8'h00};
      vecs[3] = '{8'hAA, 1'b1, 1'b1, 1, 0, 0, 1, 8'hAA};
      vecs[4] = '{8'hFF, 1'b1, 1'b1, 1, 0, 0, 1, 8'hFF};
      vecs[5] = '{8'h00, 1'b0, 1'b1, 0, 1, 0, 1, 8'h00};
      vecs[6] = '{8'h00, 1'b0, 1'b0, 0, 0, 1, 0, 8'h00};

      wait_clk(3);
      check("reset_rx_valid", 32'(rx_valid), 0);
      check("reset_rx_data", 32'(rx_data), 0);
      check("reset_fifo_count", 32'(fifo_count), 0);
      check("reset_pulses", 32'(rx_done_tick | parity_err | frame_err | overflow), 0);
      @(negedge clk); reset = 1'b0;
      wait_clk(5);

      // Frame table: each row is one frame, then a single pop clears both FIFOs.
      for (int r = 0; r < 7; r++) begin
         d_done = n_done; d_perr = n_perr; d_ferr = n_ferr;
         d_npdone = np_done; d_npferr = np_ferr;
         send_frame(vecs[r].data, vecs[r].par, vecs[r].stop, -1, 1'b0, PS2_FRAME_BITS);
         wait_clk(5);
         check($sformatf("v%0d_done", r), n_done - d_done, vecs[r].done);
         check($sformatf("v%0d_parity_err", r), n_perr - d_perr, vecs[r].perr);
         check($sformatf("v%0d_frame_err", r), n_ferr - d_ferr, vecs[r].ferr);
         check($sformatf("v%0d_count", r), 32'(fifo_count), vecs[r].done);
         check($sformatf("v%0d_valid", r), 32'(rx_valid), vecs[r].done);
         check($sformatf("v%0d_data", r), 32'(rx_data), 32'(vecs[r].head));
         check($sformatf("v%0d_np_done", r), np_done - d_npdone, vecs[r].np_done);
         check($sformatf("v%0d_np_frame_err", r), np_ferr - d_npferr, 32'(!vecs[r].stop));
         check($sformatf("v%0d_np_data", r), 32'(np_rx_data), vecs[r].np_done ? 32'(vecs[r].data) : 0);
         pulse_rd();
         check($sformatf("v%0d_pop_valid", r), 32'(rx_valid), 0);
         check($sformatf("v%0d_pop_data", r), 32'(rx_data), 0);
         check($sformatf("v%0d_pop_count", r), 32'(fifo_count), 0);
         check($sformatf("v%0d_np_pop_valid", r), 32'(np_valid), 0);
         check($sformatf("v%0d_np_pop_count", r), 32'(np_count), 0);
      end

      // rx_en low: the whole frame is ignored.
      d_done = n_done; d_perr = n_perr; d_ferr = n_ferr;
      rx_en = 1'b0;
      send_frame(8'h1C, 1'b0, 1'b1, -1, 1'b0, PS2_FRAME_BITS);
      wait_clk(5);
      rx_en = 1'b1;
      check("rx_en_gate_pulses", (n_done - d_done) + (n_perr - d_perr) + (n_ferr - d_ferr), 0);
      check("rx_en_gate_count", 32'(fifo_count), 0);

      // Glitches on ps2c in IDLE and mid-DATA.
      d_done = n_done; d_perr = n_perr; d_ferr = n_ferr;
      @(negedge clk); ps2c = 1'b0;
      wait_clk(3); ps2c = 1'b1;
      wait_clk(20);
      check("idle_glitch_pulses", (n_done - d_done) + (n_perr - d_perr) + (n_ferr - d_ferr), 0);
      check("idle_glitch_count", 32'(fifo_count), 0);
      send_frame(8'h55, 1'b1, 1'b1, 3, 1'b0, PS2_FRAME_BITS);
      wait_clk(5);
      check("glitch_frame_done", n_done - d_done, 1);
      check("glitch_frame_errs", (n_perr - d_perr) + (n_ferr - d_ferr), 0);
      check("glitch_frame_data", 32'(rx_data), 32'h55);
      pulse_rd();

      // Five frames with no reads: the fifth overflows.
      d_done = n_done; d_ovf = n_ovf; d_npovf = np_ovf;
      for (int b = 1; b <= 5; b++) begin
         bv = 8'(b);
         send_frame(bv, ~^bv, 1'b1, -1, 1'b0, PS2_FRAME_BITS);
      end
      wait_clk(5);
      check("fill_done", n_done - d_done, 4);
      check("fill_overflow", n_ovf - d_ovf, 1);
      check("fill_np_overflow", np_ovf - d_npovf, 1);
      check("fill_count", 32'(fifo_count), 4);
      for (int b = 1; b <= 4; b++) begin
         check($sformatf("drain_%0d", b), 32'(rx_data), b);
         pulse_rd();
      end
      check("drain_empty", 32'(rx_valid), 0);

      // Full FIFO with a pop landing in the same cycle as the push.
      for (int b = 8'h11; b <= 8'h14; b++) begin
         bv = 8'(b);
         send_frame(bv, ~^bv, 1'b1, -1, 1'b0, PS2_FRAME_BITS);
      end
      d_done = n_done; d_ovf = n_ovf;
      send_frame(8'h15, ~^8'h15, 1'b1, -1, 1'b1, PS2_FRAME_BITS);
      wait_clk(5);
      check("coincident_done", n_done - d_done, 1);
      check("coincident_overflow", n_ovf - d_ovf, 0);
      check("coincident_count", 32'(fifo_count), 4);
      for (int b = 8'h12; b <= 8'h15; b++) begin
         check($sformatf("coincident_drain_%0h", b), 32'(rx_data), b);
         pulse_rd();
      end

      // Watchdog: start + 3 data bits, then ps2c stays high.
      d_ferr = n_ferr; d_done = n_done;
      send_frame(8'hAA, 1'b1, 1'b1, -1, 1'b0, 4);
      t = 29;
      found = 1'b0;
      while (t < 400 && !found) begin
         @(negedge clk);
         t++;
         if (frame_err) found = 1'b1;
      end
      check("timeout_seen", 32'(found), 1);
      check("timeout_latency", t, TIMEOUT_CYC + EDGE_LAT);
      wait_clk(5);
      check("timeout_frame_err_count", n_ferr - d_ferr, 1);
      check("timeout_no_done", n_done - d_done, 0);
      send_frame(8'hAA, 1'b1, 1'b1, -1, 1'b0, PS2_FRAME_BITS);
      wait_clk(5);
      check("post_timeout_done", n_done - d_done, 1);
      check("post_timeout_data", 32'(rx_data), 32'hAA);

      // Reset mid-frame with a byte still queued.
      send_frame(8'h1C, 1'b1, 1'b1, -1, 1'b0, 4);
      d_done = n_done; d_perr = n_perr; d_ferr = n_ferr; d_ovf = n_ovf;
      @(negedge clk); reset = 1'b1;
      wait_clk(2);
      check("midreset_valid", 32'(rx_valid), 0);
      check("midreset_data", 32'(rx_data), 0);
      check("midreset_count", 32'(fifo_count), 0);
      @(negedge clk); reset = 1'b0;
      wait_clk(TIMEOUT_CYC + 50);
      check("midreset_no_pulses", (n_done - d_done) + (n_perr - d_perr) + (n_ferr - d_ferr) + (n_ovf - d_ovf), 0);
      send_frame(8'hAA, 1'b1, 1'b1, -1, 1'b0, PS2_FRAME_BITS);
      wait_clk(5);
      check("post_reset_done", n_done - d_done, 1);
      check("post_reset_data", 32'(rx_data), 32'hAA);
      check("np_never_parity_err", np_perr, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
